// File: rtl/riscv_core_pkg.sv
// rtl/riscv_core_pkg.sv - shared core types: machine word and RV32M multiply decode
package riscv_core_pkg;

   typedef logic [31:0] word_t;

   // funct3 encodings shared with the ID-stage decoder; 3'b1xx is not a multiply
   typedef enum logic [2:0] {
      MUL_OP_MUL    = 3'b000,
      MUL_OP_MULH   = 3'b001,
      MUL_OP_MULHSU = 3'b010,
      MUL_OP_MULHU  = 3'b011
   } mul_op_e;

   localparam int MUL_LATENCY_MIN = 1;
   localparam int MUL_LATENCY_MAX = 8;

endpackage

// File: rtl/mul_pipe_ctrl.sv
// rtl/mul_pipe_ctrl.sv - valid chain, global stall/flush and perf counters for mul_pipe_unit
// Perf counters exist only when MUL_PIPE_PERF_CNT_EN is defined.
module mul_pipe_ctrl
   import riscv_core_pkg::*;
#(
   parameter int LATENCY = 3
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               i_in_valid,
   input  logic               i_flush,
   input  logic               i_out_ready,
   output logic               o_in_ready,
   output logic               o_out_valid,
   output logic [LATENCY-1:0] o_stage_en,
   output logic [31:0]        o_perf_ops,
   output logic [31:0]        o_perf_stall
);

   if (LATENCY < MUL_LATENCY_MIN || LATENCY > MUL_LATENCY_MAX) begin : g_bad_latency
      $fatal(1, "mul_pipe_ctrl: LATENCY must be within 1..8");
   end

   logic [LATENCY-1:0] r_valid;
   logic               w_advance;
   logic               w_accept;

   // One stall signal freezes every stage, bubbles included, so order is preserved
   assign o_out_valid = r_valid[LATENCY-1];
   assign w_advance   = !(o_out_valid && !i_out_ready);
   assign o_in_ready  = w_advance && !i_flush;
   assign w_accept    = i_in_valid && o_in_ready;
   assign o_stage_en  = {LATENCY{w_advance}};

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_valid <= '0;
      end else if (i_flush) begin
         r_valid <= '0;
      end else if (w_advance) begin
         r_valid[0] <= w_accept;
         for (int k = 1; k < LATENCY; k++) begin
            r_valid[k] <= r_valid[k-1];
         end
      end
   end

`ifdef MUL_PIPE_PERF_CNT_EN
   logic [31:0] r_perf_ops;
   logic [31:0] r_perf_stall;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_perf_ops   <= '0;
         r_perf_stall <= '0;
      end else begin
         if (o_out_valid && i_out_ready) r_perf_ops <= r_perf_ops + 32'd1;
         if (o_out_valid && !i_out_ready) r_perf_stall <= r_perf_stall + 32'd1;
      end
   end

   assign o_perf_ops   = r_perf_ops;
   assign o_perf_stall = r_perf_stall;
`else
   assign o_perf_ops   = '0;
   assign o_perf_stall = '0;
`endif

endmodule

// File: rtl/mul_pipe_unit.sv
// rtl/mul_pipe_unit.sv - tagged, fully pipelined RV32M multiplier with global stall and flush
// Optional perf counters: define MUL_PIPE_PERF_CNT_EN.
module mul_pipe_unit
   import riscv_core_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int LATENCY    = 3,
   parameter int TAG_WIDTH  = 4
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  in_valid_i,
   output logic                  in_ready_o,
   input  logic [2:0]            op_i,
   input  logic [DATA_WIDTH-1:0] a_i,
   input  logic [DATA_WIDTH-1:0] b_i,
   input  logic [TAG_WIDTH-1:0]  tag_i,
   input  logic                  flush_i,
   output logic                  out_valid_o,
   input  logic                  out_ready_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic [TAG_WIDTH-1:0]  tag_o,
   output logic                  err_o,
   output logic [31:0]           perf_ops_o,
   output logic [31:0]           perf_stall_o
);

   localparam int W  = DATA_WIDTH;
   localparam int PW = 2 * DATA_WIDTH;

   logic [LATENCY-1:0]    w_stage_en;
   logic signed [W:0]     w_a_ext;
   logic signed [W:0]     w_b_ext;
   logic signed [W:0]     r_a;
   logic signed [W:0]     r_b;
   logic [2:0]            r_op  [LATENCY];
   logic [TAG_WIDTH-1:0]  r_tag [LATENCY];
   logic signed [PW-1:0]  w_prod1;
   logic [PW-1:0]         w_prod_last;

   mul_pipe_ctrl #(
      .LATENCY (LATENCY)
   ) u_ctrl (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .i_in_valid   (in_valid_i),
      .i_flush      (flush_i),
      .i_out_ready  (out_ready_i),
      .o_in_ready   (in_ready_o),
      .o_out_valid  (out_valid_o),
      .o_stage_en   (w_stage_en),
      .o_perf_ops   (perf_ops_o),
      .o_perf_stall (perf_stall_o)
   );

   // One extra bit lets a single signed multiplier cover all four signedness mixes
   always_comb begin
      w_a_ext = (op_i == MUL_OP_MULHU) ? {1'b0, a_i} : {a_i[W-1], a_i};
      w_b_ext = (op_i == MUL_OP_MUL || op_i == MUL_OP_MULH) ? {b_i[W-1], b_i} : {1'b0, b_i};
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_a <= '0;
         r_b <= '0;
         for (int k = 0; k < LATENCY; k++) begin
            r_op[k]  <= '0;
            r_tag[k] <= '0;
         end
      end else begin
         if (w_stage_en[0]) begin
            r_a      <= w_a_ext;
            r_b      <= w_b_ext;
            r_op[0]  <= op_i;
            r_tag[0] <= tag_i;
         end
         for (int k = 1; k < LATENCY; k++) begin
            if (w_stage_en[k]) begin
               r_op[k]  <= r_op[k-1];
               r_tag[k] <= r_tag[k-1];
            end
         end
      end
   end

   // Only the low 2W bits of the (W+1)x(W+1) product are ever needed
   assign w_prod1 = PW'(r_a) * PW'(r_b);

   if (LATENCY == 1) begin : g_comb_prod
      assign w_prod_last = w_prod1;
   end else begin : g_reg_prod
      logic [PW-1:0] r_prod [1:LATENCY-1];

      always_ff @(posedge clk_i or negedge rst_ni) begin
         if (!rst_ni) begin
            for (int k = 1; k < LATENCY; k++) begin
               r_prod[k] <= '0;
            end
         end else begin
            if (w_stage_en[1]) r_prod[1] <= w_prod1;
            for (int k = 2; k < LATENCY; k++) begin
               if (w_stage_en[k]) r_prod[k] <= r_prod[k-1];
            end
         end
      end

      assign w_prod_last = r_prod[LATENCY-1];
   end

   always_comb begin
      result_o = '0;
      case (r_op[LATENCY-1])
         MUL_OP_MUL:                             result_o = w_prod_last[W-1:0];
         MUL_OP_MULH, MUL_OP_MULHSU, MUL_OP_MULHU: result_o = w_prod_last[PW-1:W];
         default:                                result_o = '0;
      endcase
   end

   assign err_o = r_op[LATENCY-1][2];
   assign tag_o = r_tag[LATENCY-1];

endmodule
